// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// States, port ids and default memory geometry.
package dmem_arb_pkg;
  localparam int MEM_DEPTH  = 256;
  localparam int DEPTH_LOG2 = $clog2(MEM_DEPTH);

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACCESS
  } state_t;
endpackage

// File: rtl/dmem_rr_arb.sv
// Two-request round-robin picker.
// Remembers the last grant so ties alternate between the ports.
module dmem_rr_arb
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic ext_req,
  input  logic update,
  output logic grant,
  output logic winner
);
  logic last;

  always_comb begin
    grant  = cpu_req | ext_req;
    winner = PORT_CPU;
    if (cpu_req && ext_req)
      winner = ~last;
    else if (ext_req)
      winner = PORT_EXT;
  end

  // Starts as EXT so the CPU wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last <= PORT_EXT;
    else if (update)
      last <= winner;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU and EXT ports share one memory port.
// Clears the whole array after every reset before granting access.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              init_busy
);
  localparam int PW = $clog2(DEPTH);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic              sel;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              grant;
  logic              winner;
  logic              update;
  logic [DATA_W-1:0] rd;

  assign update = (state == IDLE) && grant;

  dmem_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .cpu_req (cpu_req),
    .ext_req (ext_req),
    .update  (update),
    .grant   (grant),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      ptr     <= '0;
      sel     <= PORT_CPU;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == PW'(DEPTH - 1))
            state <= IDLE;
        end
        IDLE: begin
          if (grant) begin
            sel     <= winner;
            l_we    <= winner ? ext_we : cpu_we;
            l_addr  <= winner ? ext_addr : cpu_addr;
            l_wdata <= winner ? ext_wdata : cpu_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

  assign rd = l_we ? '0 : mem_read_data;

  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    cpu_ack         = 1'b0;
    ext_ack         = 1'b0;
    cpu_rdata       = '0;
    ext_rdata       = '0;
    init_busy       = 1'b0;
    unique case (state)
      CLEAR: begin
        init_busy       = 1'b1;
        mem_write_en    = 1'b1;
        mem_access_addr = ADDR_W'({ptr, 2'b00});
      end
      ACCESS: begin
        mem_access_addr = l_addr;
        mem_write_data  = l_wdata;
        mem_write_en    = l_we;
        mem_read        = ~l_we;
        cpu_ack         = (sel == PORT_CPU);
        ext_ack         = (sel == PORT_EXT);
        cpu_rdata       = (sel == PORT_CPU) ? rd : '0;
        ext_rdata       = (sel == PORT_EXT) ? rd : '0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory.
// Vector table for single accesses plus hand-written corner sequences.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        ext_req = 0, ext_we = 0;
  logic [15:0] ext_addr = 0, ext_wdata = 0;
  logic        ext_ack;
  logic [15:0] ext_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, init_busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_ack         (cpu_ack),
    .cpu_rdata       (cpu_rdata),
    .ext_req         (ext_req),
    .ext_we          (ext_we),
    .ext_addr        (ext_addr),
    .ext_wdata       (ext_wdata),
    .ext_ack         (ext_ack),
    .ext_rdata       (ext_rdata),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .init_busy       (init_busy)
  );

  // Memory starts filled with non-zero junk so the clear sweep is visible.
  logic [15:0] mem [256];
  logic        filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= 16'hA5A5 ^ 16'(i);
      filled <= 1'b1;
    end else if (mem_write_en) begin
      mem[mem_access_addr[9:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_access_addr[9:2]];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!(mem_write_en && !mem_read && mem_access_addr == 16'(i * 4)
            && mem_write_data == 16'h0 && init_busy
            && !cpu_ack && !ext_ack))
        bad++;
    end
    chk({name, " sweep bad cycles"}, bad, 0);
    @(negedge clk);
    chk({name, " init_busy after sweep"}, init_busy, 0);
  endtask

  task automatic access(input logic port, input logic we,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rd, output int lat);
    logic got = 1'b0;
    @(posedge clk); #1;
    if (port == 1'b0) begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ext_req = 1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    end
    lat = 0;
    rd = '0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (port ? ext_ack : cpu_ack) begin
        got = 1'b1;
        rd = port ? ext_rdata : cpu_rdata;
      end
    end
    @(posedge clk); #1;
    cpu_req = 0;
    ext_req = 0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] rd;
    int lat;

    vecs[0] = '{1'b1, 1'b0, 16'h03FC, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 16'h0400, 16'h5A5A, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};
    vecs[5] = '{1'b0, 1'b1, 16'h03FE, 16'h1111, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 16'h03FC, 16'h0000, 16'h1111};

    // EXT read of word 0 held high straight out of reset
    ext_req = 1; ext_we = 0; ext_addr = 16'h0000;
    @(negedge clk);
    chk("reset cpu_ack", cpu_ack, 0);
    chk("reset ext_ack", ext_ack, 0);
    chk("reset rdata", {cpu_rdata, ext_rdata}, 0);
    chk("reset init_busy", init_busy, 1);
    chk("reset mem_write_en", mem_write_en, 1);
    chk("reset mem addr", mem_access_addr, 16'h0000);
    @(posedge clk); #1;
    reset = 0;
    sweep("first");
    chk("idle mem strobes", {mem_write_en, mem_read}, 2'b00);
    chk("no ext_ack yet", ext_ack, 0);
    @(negedge clk);
    chk("held ext_ack", ext_ack, 1);
    chk("held ext_rdata", ext_rdata, 16'h0000);
    @(posedge clk); #1;
    ext_req = 0;

    foreach (vecs[i]) begin
      access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      chk($sformatf("vec%0d latency", i), lat, 2);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
    end

    // Both ports held: expect CPU, EXT, CPU, EXT acks 2 cycles apart
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    ext_req = 1; ext_we = 0; ext_addr = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      logic ec, ee;
      @(negedge clk);
      ec = (k == 2 || k == 6);
      ee = (k == 4 || k == 8);
      chk($sformatf("rr acks k=%0d", k), {cpu_ack, ext_ack}, {ec, ee});
      chk($sformatf("rr rdata k=%0d", k), {cpu_rdata, ext_rdata},
          {ec ? 16'hBEEF : 16'h0, ee ? 16'h5A5A : 16'h0});
    end
    @(posedge clk); #1;
    cpu_req = 0;
    ext_req = 0;

    // Reset lands in the ACCESS cycle of a CPU write
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    @(negedge clk);
    @(posedge clk); #1;
    chk("mid access write_en", mem_write_en, 1);
    reset = 1;
    @(negedge clk);
    chk("mid reset cpu_ack", cpu_ack, 0);
    chk("mid reset init_busy", init_busy, 1);
    chk("mid reset mem addr", mem_access_addr, 16'h0000);
    @(posedge clk); #1;
    reset = 0;
    cpu_req = 0;
    sweep("second");

    access(1'b0, 1'b0, 16'h0020, 16'h0, rd, lat);
    chk("post reset 0x20 latency", lat, 2);
    chk("post reset 0x20 rdata", rd, 16'h0000);
    access(1'b1, 1'b0, 16'h0010, 16'h0, rd, lat);
    chk("post reset 0x10 rdata", rd, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
